// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquad sections with per-section saturate and round requantisation.
// Latency: CASCADE_LEVEL cycles from the din_vld edge to dout; one register stage per section.
// Backpressure: none; fully pipelined, accepts a sample every cycle, dout holds between updates.

// Signed clamp from IN_W to OUT_W bits by dropping integer MSBs.
module iir_sat #(
    parameter int IN_W  = 35,
    parameter int OUT_W = 29
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    logic [IN_W-OUT_W:0] upper;
    assign upper = din[IN_W-1:OUT_W-1];

    // Pass through when all dropped bits match the new sign bit, otherwise clamp to an extreme.
    always_comb begin
        if ((&upper) || (~|upper))
            dout = din[OUT_W-1:0];
        else if (din[IN_W-1])
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        else
            dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
endmodule

// Drop IN_W-OUT_W LSBs, round to nearest with ties away from zero, clamp positive overflow.
module iir_round #(
    parameter int IN_W  = 29,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam int D = IN_W - OUT_W;
    localparam logic [IN_W:0] HALF = {{(OUT_W+1){1'b0}}, 1'b1, {(D-1){1'b0}}};

    logic [IN_W:0]  bias;
    logic [IN_W:0]  sum;
    logic [OUT_W:0] rnd;
    logic           unused_lsbs;

    // Negative values get half minus one so that a floor shift rounds ties away from zero.
    assign bias        = din[IN_W-1] ? (HALF - 1'b1) : HALF;
    assign sum         = {din[IN_W-1], din} + bias;
    assign rnd         = sum[IN_W:D];
    assign unused_lsbs = ^sum[D-1:0];

    // Only a positive value can round past the top of the output range.
    always_comb begin
        if (!rnd[OUT_W] && rnd[OUT_W-1])
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        else
            dout = rnd[OUT_W-1:0];
    end
endmodule

module iir_biquad_cascade #(
    parameter int CASCADE_LEVEL = 2,
    parameter int DWIDTH        = 16,
    parameter int CWIDTH        = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            block_en,
    input  logic [CASCADE_LEVEL*CWIDTH*5-1:0] coefs,
    input  logic                            din_vld,
    input  logic [DWIDTH-1:0]               din,
    output logic [DWIDTH-1:0]               dout
);
    localparam int PW = DWIDTH + CWIDTH;
    localparam int AW = DWIDTH + CWIDTH + 3;
    localparam int SW = DWIDTH + CWIDTH - 3;

    // Stage 0 is the block input; stage s+1 is the registered output of section s.
    logic [CASCADE_LEVEL:0][DWIDTH-1:0] stg_dat;
    logic [CASCADE_LEVEL:0]             stg_vld;

    assign stg_dat[0] = din;
    assign stg_vld[0] = din_vld;
    assign dout       = stg_dat[CASCADE_LEVEL];

    for (genvar s = 0; s < CASCADE_LEVEL; s++) begin : g_sec
        logic signed [CWIDTH-1:0] b0, b1, b2, a1, a2;
        logic signed [DWIDTH-1:0] x_in, x1, x2, y1, y2, y_q, y_reg;
        logic signed [PW-1:0]     p0, p1, p2, p3, p4;
        logic signed [AW-1:0]     e0, e1, e2, e3, e4, acc;
        logic signed [SW-1:0]     acc_sat;
        logic                     v_reg;

        assign b0 = coefs[(5*s+0)*CWIDTH +: CWIDTH];
        assign b1 = coefs[(5*s+1)*CWIDTH +: CWIDTH];
        assign b2 = coefs[(5*s+2)*CWIDTH +: CWIDTH];
        assign a1 = coefs[(5*s+3)*CWIDTH +: CWIDTH];
        assign a2 = coefs[(5*s+4)*CWIDTH +: CWIDTH];

        assign x_in = stg_dat[s];

        // Full-precision products, sign-extended into an accumulator wide enough to never overflow.
        assign p0  = x_in * b0;
        assign p1  = x1 * b1;
        assign p2  = x2 * b2;
        assign p3  = y1 * a1;
        assign p4  = y2 * a2;
        assign e0  = p0;
        assign e1  = p1;
        assign e2  = p2;
        assign e3  = p3;
        assign e4  = p4;
        assign acc = e0 + e1 + e2 - e3 - e4;

        iir_sat #(.IN_W(AW), .OUT_W(SW)) u_sat (
            .din  (acc),
            .dout (acc_sat)
        );

        iir_round #(.IN_W(SW), .OUT_W(DWIDTH)) u_round (
            .din  (acc_sat),
            .dout (y_q)
        );

        // Section state and output register: cleared by reset or disable, advanced only on input valid.
        always_ff @(posedge clk) begin
            if (!rstn || !block_en) begin
                x1    <= '0;
                x2    <= '0;
                y1    <= '0;
                y2    <= '0;
                y_reg <= '0;
                v_reg <= 1'b0;
            end else begin
                v_reg <= stg_vld[s];
                if (stg_vld[s]) begin
                    x2    <= x1;
                    x1    <= x_in;
                    y2    <= y1;
                    y1    <= y_q;
                    y_reg <= y_q;
                end
            end
        end

        assign stg_dat[s+1] = y_reg;
        assign stg_vld[s+1] = v_reg;
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for the biquad cascade: reset, passthrough, rounding, saturation, recursion, clear.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed in Q3.13 (1.0 = 8192).
module tb_iir_biquad_cascade;
    logic         clk = 1'b0;
    logic         rstn;
    logic         block_en;
    logic [159:0] coefs;
    logic         din_vld;
    logic [15:0]  din;
    logic [15:0]  dout;

    int cmp_cnt = 0;
    int err_cnt = 0;

    iir_biquad_cascade #(.CASCADE_LEVEL(2), .DWIDTH(16), .CWIDTH(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .block_en (block_en),
        .coefs    (coefs),
        .din_vld  (din_vld),
        .din      (din),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int expv);
        logic [15:0] e;
        e = 16'(expv);
        cmp_cnt++;
        if (dout !== e) begin
            err_cnt++;
            $display("FAIL %s: dout=%0d expected=%0d", name, $signed(dout), $signed(e));
        end
    endtask

    task automatic set_coefs(input int s0_b0, input int s0_a1, input int s1_b0);
        coefs = '0;
        coefs[0*16 +: 16] = 16'(s0_b0);
        coefs[3*16 +: 16] = 16'(s0_a1);
        coefs[5*16 +: 16] = 16'(s1_b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Pulse one sample; check dout is unchanged after one cycle and updated after two.
    task automatic send(input string name, input int x, input int prev, input int expv);
        @(negedge clk);
        din     = 16'(x);
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        din     = 16'h5a5a;
        check({name, "_hold"}, prev);
        @(negedge clk);
        check(name, expv);
    endtask

    task automatic clear_block;
        @(negedge clk);
        block_en = 1'b0;
        @(negedge clk);
        block_en = 1'b1;
    endtask

    task automatic test_reset;
        rstn     = 1'b0;
        block_en = 1'b1;
        din      = 16'd1234;
        din_vld  = 1'b1;
        set_coefs(8192, 0, 8192);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 0);
        end
        rstn    = 1'b1;
        din_vld = 1'b0;
        @(negedge clk);
        check("reset_release", 0);
    endtask

    task automatic test_passthrough;
        set_coefs(8192, 0, 8192);
        send("pass_1000", 1000, 0, 1000);
        idle(3);
        check("pass_held", 1000);
        send("pass_min", -32768, 1000, -32768);
        send("pass_max", 32767, -32768, 32767);
    endtask

    task automatic test_rounding;
        clear_block();
        set_coefs(4096, 0, 8192);
        send("round_p3", 3, 0, 2);
        send("round_m3", -3, 2, -2);
        send("round_p5", 5, -2, 3);
        send("round_p1", 1, 3, 1);
    endtask

    task automatic test_saturation;
        clear_block();
        set_coefs(24576, 0, 8192);
        send("sat_pos", 20000, 0, 32767);
        send("sat_neg", -20000, 32767, -32768);
        send("sat_in_range", 10000, -32768, 30000);
    endtask

    task automatic test_recursion;
        int exp_seq [12] = '{1000, 500, 250, 125, 63, 32, 16, 8, 4, 2, 1, 1};
        int prev;
        clear_block();
        set_coefs(8192, -4096, 8192);
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            send($sformatf("recur_%0d", i), (i == 0) ? 1000 : 0, prev, exp_seq[i]);
            prev = exp_seq[i];
            idle(28);
        end
    endtask

    task automatic test_clear;
        int exp_seq [3] = '{1000, 500, 250};
        int prev;
        clear_block();
        set_coefs(8192, -4096, 8192);
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            send($sformatf("clr_pre_%0d", i), (i == 0) ? 1000 : 0, prev, exp_seq[i]);
            prev = exp_seq[i];
            idle(28);
        end
        clear_block();
        check("clr_dout_zero", 0);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send($sformatf("clr_post_%0d", i), 0, 0, 0);
            idle(28);
        end
    endtask

    // A sample in flight when block_en drops must never reach dout.
    task automatic test_inflight_discard;
        set_coefs(8192, 0, 8192);
        @(negedge clk);
        din     = 16'd777;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld  = 1'b0;
        block_en = 1'b0;
        @(negedge clk);
        block_en = 1'b1;
        check("discard_0", 0);
        @(negedge clk);
        check("discard_1", 0);
        idle(2);
        check("discard_2", 0);
    endtask

    task automatic test_back_to_back;
        clear_block();
        set_coefs(8192, 0, 8192);
        @(negedge clk);
        din_vld = 1'b1;
        din     = 16'd11;
        @(negedge clk);
        din     = 16'd22;
        @(negedge clk);
        din     = 16'd33;
        check("b2b_0", 11);
        @(negedge clk);
        din_vld = 1'b0;
        check("b2b_1", 22);
        @(negedge clk);
        check("b2b_2", 33);
        idle(2);
        check("b2b_held", 33);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rounding();
        test_saturation();
        test_recursion();
        test_clear();
        test_inflight_discard();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
- Cascade of CASCADE_LEVEL second-order IIR sections (biquads) in direct form I, fixed-point, driven by a sparse sample strobe.
- Each section saturates and rounds its output back to DWIDTH bits before feeding the next section.
- Sits between a scaled sample source and downstream logic that reads dout.
- The whole coefficient set is supplied as one static packed bus.

Parameters:
- CASCADE_LEVEL, 2, number of biquad sections.
- DWIDTH, 16, signed sample width for din, dout and inter-stage data.
- CWIDTH, 16, signed coefficient width. Format Q3.(CWIDTH-3): sign plus 2 integer bits, CWIDTH-3 fraction bits. 1.0 = 2^(CWIDTH-3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- block_en  in  1  block enable. 0 = synchronous clear and hold.
- coefs  in  CASCADE_LEVEL*CWIDTH*5  packed coefficients.
  - Section s, coefficient k occupies bits [(5*s+k)*CWIDTH +: CWIDTH].
  - k = 0..4 maps to b0, b1, b2, a1, a2.
  - Section 0 sits at the LSBs.
- din_vld  in  1  one-cycle strobe: din holds a new sample.
- din  in  DWIDTH  signed input sample.
- dout  out  DWIDTH  signed filtered output, registered, held between updates.

Behaviour:
- Reset (rstn=0 at a clock edge): all section states x1, x2, y1, y2 = 0, all pipeline valids = 0, dout = 0.
- block_en=0: same clear as reset on every clock; din_vld is ignored. Normal operation resumes on the first din_vld after block_en returns to 1.
- Per section, on its input-valid: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 (a0 implicitly 1).
  - Products are full precision, DWIDTH+CWIDTH bits.
  - Accumulation is exact, DWIDTH+CWIDTH+3 bits, no intermediate overflow.
- Requantisation of y to DWIDTH:
  - Saturate step: signed clamp of the accumulator to the range of DWIDTH+CWIDTH-3 bits. Drops integer MSBs; overflow clamps to max positive / min negative.
  - Round step: drop CWIDTH-3 LSBs, round to nearest, ties away from zero. If rounding a positive value overflows, clamp to max positive.
  - Implement each step as a reusable sat/round helper with parameters IN_W, OUT_W, purely combinational.
- State update, on the same edge the section output is registered: x2<=x1, x1<=x, y2<=y1, y1<=y_quantised. State changes only on section-valid.
- Pipeline:
  - Section s registers its output and valid one cycle after its input valid.
  - Section 0 input is din/din_vld; section s>0 input is section s-1 registered output/valid.
  - dout = last section's registered output, so latency is CASCADE_LEVEL cycles from the din_vld edge.
  - Fully pipelined: back-to-back din_vld is accepted every cycle.
- coefs are sampled combinationally when each section computes. Changing coefs mid-stream affects the next computation only; there is no glitch on dout.
- dout changes only when the last section's valid fires; otherwise it holds.
- Reset or block_en=0 mid-pipeline discards in-flight samples; no stale dout afterwards.

Test Plan:
All scenarios use DWIDTH=16, CWIDTH=16, CASCADE_LEVEL=2, so 1.0 = 8192.

1. Reset: assert rstn=0 for 3 cycles with din=1234 and din_vld=1 -> dout=0 throughout and 1 cycle after release.
2. Passthrough, both sections b0=8192 and others 0:
   - din=1000 pulse -> dout=1000 exactly 2 cycles later, held until the next pulse.
   - din=-32768 -> dout=-32768.
3. Rounding, section0 b0=4096, section1 passthrough:
   - din=3 -> dout=2.
   - din=-3 -> dout=-2.
   - din=5 -> 3.
   - din=1 -> 1.
4. Saturation, section0 b0=24576 (3.0), section1 passthrough:
   - din=20000 -> 32767.
   - din=-20000 -> -32768.
   - din=10000 -> 30000.
5. Recursion, section0 b0=8192 and a1=-4096 (y=x+0.5*y1), section1 passthrough:
   - Impulse 1000 then zeros, 31-cycle spacing -> dout sequence 1000, 500, 250, 125, 63, 32, 16, 8, 4, 2, 1, 1, ...
6. Clear: during scenario 5, drop block_en for 1 cycle after the 3rd output, then resume with zeros -> dout=0 and all further outputs are 0.
